// File: rtl/xadc_scan_pwm.sv
// XADC DRP scan sequencer with one noise-masked PWM indicator per channel.
// Optional per-channel 4-sample running average: define XADC_SCAN_AVG_EN.
module xadc_scan_pwm #(
    parameter int                  NUM_CH       = 4,
    parameter logic [NUM_CH*7-1:0] CH_ADDR      = {7'h16, 7'h1f, 7'h17, 7'h1e},
    parameter int                  PWM_PERIOD   = 4096,
    parameter int                  NOISE_BITS   = 4,
    parameter int                  DRDY_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic                 eoc_in,
    input  logic [4:0]           channel_in,
    input  logic                 drdy_in,
    input  logic [15:0]          do_in,
    output logic [6:0]           daddr_out,
    output logic                 den_out,
    output logic [NUM_CH*12-1:0] sample_out,
    output logic                 sample_valid,
    output logic [3:0]           sample_ch,
    output logic                 timeout_err,
    output logic [NUM_CH-1:0]    pwm_out
);
    localparam int         CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int         TW         = (DRDY_TIMEOUT > 1) ? $clog2(DRDY_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(DRDY_TIMEOUT);
    localparam logic [11:0] PCNT_LAST  = 12'(PWM_PERIOD - 1);
    localparam logic [11:0] NOISE_MASK = 12'(12'hFFF << NOISE_BITS);

    typedef enum logic [1:0] {IDLE, WAIT_EOC, WAIT_DRDY, ADVANCE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cur_reg;
    logic [TW-1:0]   timer_reg;
    logic [11:0]     pcnt_reg;
    logic [6:0]      addr_tab [NUM_CH];
    logic [6:0]      cur_addr;
    logic [CW-1:0]   low_idx, above_idx, next_idx;
    logic            any_en, above_found;
    logic            start_read, accept, timer_hit, timeout_hit;
    logic            wr_en;
    logic [CW-1:0]   wr_ch;
    logic [11:0]     wr_data;
    logic            unused_bits;

    assign unused_bits = ^do_in[3:0];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_addr
            assign addr_tab[gi] = CH_ADDR[7*gi +: 7];
        end
    endgenerate

    // Lowest enabled channel overall, and lowest enabled strictly above cur.
    always_comb begin
        low_idx     = '0;
        above_idx   = '0;
        any_en      = 1'b0;
        above_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_en[i]) begin
                any_en  = 1'b1;
                low_idx = CW'(i);
                if (i > int'(cur_reg)) begin
                    above_found = 1'b1;
                    above_idx   = CW'(i);
                end
            end
        end
        next_idx = above_found ? above_idx : low_idx;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (any_en) state_next = WAIT_EOC;
            WAIT_EOC:  if (eoc_in) state_next = WAIT_DRDY;
            WAIT_DRDY: if (drdy_in || timer_hit) state_next = ADVANCE;
            ADVANCE:   state_next = any_en ? WAIT_EOC : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        cur_addr    = addr_tab[cur_reg];
        start_read  = (state_reg == WAIT_EOC) && eoc_in;
        timer_hit   = (timer_reg == TIMER_LAST);
        accept      = (state_reg == WAIT_DRDY) && drdy_in &&
                      (channel_in == cur_addr[4:0]) && ch_en[cur_reg];
        timeout_hit = (state_reg == WAIT_DRDY) && !drdy_in && timer_hit;
        daddr_out   = (state_reg == IDLE) ? addr_tab[0] : cur_addr;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_reg      <= '0;
            timer_reg    <= '0;
            pcnt_reg     <= '0;
            den_out      <= 1'b0;
            timeout_err  <= 1'b0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
        end else begin
            if (state_reg == IDLE && any_en)
                cur_reg <= low_idx;
            else if (state_reg == ADVANCE && any_en)
                cur_reg <= next_idx;
            if (start_read)
                timer_reg <= '0;
            else if (state_reg == WAIT_DRDY && !timer_hit)
                timer_reg <= timer_reg + 1'b1;
            den_out <= start_read;
            if (timeout_hit)
                timeout_err <= 1'b1;
            sample_valid <= wr_en && ch_en[wr_ch];
            if (wr_en)
                sample_ch <= 4'(wr_ch);
            pcnt_reg <= (pcnt_reg == PCNT_LAST) ? 12'd0 : pcnt_reg + 12'd1;
        end
    end

`ifdef XADC_SCAN_AVG_EN
    logic            pend_reg;
    logic [CW-1:0]   pend_ch_reg;
    logic [13:0]     ch_sum [NUM_CH];

    // The average is formed from the history one clock after the accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_reg    <= 1'b0;
            pend_ch_reg <= '0;
        end else begin
            pend_reg    <= accept;
            pend_ch_reg <= cur_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hist
            logic [11:0] hist [4];
            logic        primed;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    primed <= 1'b0;
                    for (int k = 0; k < 4; k++) hist[k] <= '0;
                end else if (!ch_en[gi]) begin
                    primed <= 1'b0;
                end else if (accept && cur_reg == CW'(gi)) begin
                    primed  <= 1'b1;
                    hist[0] <= do_in[15:4];
                    for (int k = 1; k < 4; k++)
                        hist[k] <= primed ? hist[k-1] : do_in[15:4];
                end
            end
            assign ch_sum[gi] = 14'(hist[0]) + 14'(hist[1]) + 14'(hist[2]) + 14'(hist[3]);
        end
    endgenerate

    assign wr_en   = pend_reg;
    assign wr_ch   = pend_ch_reg;
    assign wr_data = ch_sum[pend_ch_reg][13:2];
`else
    assign wr_en   = accept;
    assign wr_ch   = cur_reg;
    assign wr_data = do_in[15:4];
`endif

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [11:0] sample;
            logic        pwm_bit;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    sample  <= '0;
                    pwm_bit <= 1'b0;
                end else begin
                    if (!ch_en[gi])
                        sample <= '0;
                    else if (wr_en && wr_ch == CW'(gi))
                        sample <= wr_data;
                    pwm_bit <= ch_en[gi] && (pcnt_reg < (sample & NOISE_MASK));
                end
            end
            assign sample_out[12*gi +: 12] = sample;
            assign pwm_out[gi]             = pwm_bit;
        end
    endgenerate

endmodule

// File: tb/tb_xadc_scan_pwm.sv
// Directed bench for xadc_scan_pwm: vector table of DRP reads plus timeout, disable and reset sequences.
module tb_xadc_scan_pwm;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  ch_en = 4'b0000;
    logic        eoc_in = 1'b0;
    logic [4:0]  channel_in = 5'd0;
    logic        drdy_in = 1'b0;
    logic [15:0] do_in = 16'd0;
    logic [6:0]  daddr_out;
    logic        den_out;
    logic [47:0] sample_out;
    logic        sample_valid;
    logic [3:0]  sample_ch;
    logic        timeout_err;
    logic [3:0]  pwm_out;

    int total = 0;
    int bad   = 0;

    xadc_scan_pwm dut (
        .clk(clk), .resetn(resetn), .ch_en(ch_en), .eoc_in(eoc_in),
        .channel_in(channel_in), .drdy_in(drdy_in), .do_in(do_in),
        .daddr_out(daddr_out), .den_out(den_out), .sample_out(sample_out),
        .sample_valid(sample_valid), .sample_ch(sample_ch),
        .timeout_err(timeout_err), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic [4:0]  chan;
        logic [15:0] data;
        logic [6:0]  addr;
        logic        valid;
        int          ch;
        logic [11:0] samp;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint smp(input int i);
        return longint'(sample_out[i*12 +: 12]);
    endfunction

    // Called at a negedge with the FSM in WAIT_EOC.
    task automatic txn(input vec_t v);
        ch_en  = v.en;
        eoc_in = 1'b1;
        @(negedge clk);
        eoc_in = 1'b0;
        chk("den_pulse", den_out, 1);
        chk("daddr", daddr_out, v.addr);
        drdy_in    = 1'b1;
        channel_in = v.chan;
        do_in      = v.data;
        @(negedge clk);
        drdy_in = 1'b0;
        chk("den_single", den_out, 0);
        chk("sample_valid", sample_valid, v.valid);
        if (v.valid) chk("sample_ch", sample_ch, v.ch);
        chk("sample_value", smp(v.ch), v.samp);
        $display("txn en=%b addr=%h chan=%h data=%h valid=%b ch=%0d sample=%h",
                 v.en, daddr_out, v.chan, v.data, sample_valid, v.ch, smp(v.ch));
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        eoc_in  = 1'b0;
        drdy_in = 1'b0;
        ch_en   = 4'b0000;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int c0, c3, denbad;
        vecs[0]  = '{4'b0001, 5'h1e, 16'hFFF0, 7'h1e, 1'b1, 0, 12'hFFF};
        vecs[1]  = '{4'b0001, 5'h1e, 16'h1234, 7'h1e, 1'b1, 0, 12'h123};
        vecs[2]  = '{4'b0001, 5'h17, 16'hABCD, 7'h1e, 1'b0, 0, 12'h123};
        vecs[3]  = '{4'b1001, 5'h1e, 16'h5550, 7'h1e, 1'b1, 0, 12'h555};
        vecs[4]  = '{4'b1001, 5'h16, 16'h8000, 7'h16, 1'b1, 3, 12'h800};
        vecs[5]  = '{4'b1001, 5'h1e, 16'h0010, 7'h1e, 1'b1, 0, 12'h001};
        vecs[6]  = '{4'b1001, 5'h16, 16'hFFFF, 7'h16, 1'b1, 3, 12'hFFF};
        vecs[7]  = '{4'b1111, 5'h1e, 16'h0400, 7'h1e, 1'b1, 0, 12'h040};
        vecs[8]  = '{4'b1111, 5'h17, 16'h7770, 7'h17, 1'b1, 1, 12'h777};
        vecs[9]  = '{4'b1111, 5'h1f, 16'h1110, 7'h1f, 1'b1, 2, 12'h111};
        vecs[10] = '{4'b1111, 5'h16, 16'h2220, 7'h16, 1'b1, 3, 12'h222};
        vecs[11] = '{4'b0110, 5'h1e, 16'h9990, 7'h1e, 1'b0, 0, 12'h000};
        vecs[12] = '{4'b0110, 5'h17, 16'h3330, 7'h17, 1'b1, 1, 12'h333};
        vecs[13] = '{4'b0110, 5'h1f, 16'h4440, 7'h1f, 1'b1, 2, 12'h444};

        repeat (2) @(negedge clk);
        chk("rst_den", den_out, 0);
        chk("rst_daddr", daddr_out, 7'h1e);
        chk("rst_valid", sample_valid, 0);
        chk("rst_sample_ch", sample_ch, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_samples", sample_out, 0);

        resetn = 1'b1;
        ch_en  = 4'b0001;
        @(negedge clk);
        for (int i = 0; i < 14; i++) txn(vecs[i]);

        // PWM duty with noise mask
        do_reset();
        ch_en = 4'b0001;
        @(negedge clk);
        txn('{4'b0001, 5'h1e, 16'hFFF0, 7'h1e, 1'b1, 0, 12'hFFF});
        c0 = 0; c3 = 0;
        for (int n = 0; n < 4096; n++) begin
            @(negedge clk);
            if (pwm_out[0]) c0++;
            if (pwm_out[3]) c3++;
        end
        chk("pwm0_fff_high", c0, 4080);
        chk("pwm3_off", c3, 0);
        txn('{4'b0001, 5'h1e, 16'h12F0, 7'h1e, 1'b1, 0, 12'h12F});
        c0 = 0;
        for (int n = 0; n < 4096; n++) begin
            @(negedge clk);
            if (pwm_out[0]) c0++;
        end
        chk("pwm0_masked_12f", c0, 288);

        // DRDY timeout, sticky error, next channel scanned
        do_reset();
        ch_en = 4'b0011;
        @(negedge clk);
        eoc_in = 1'b1;
        @(negedge clk);
        eoc_in = 1'b0;
        chk("to_den", den_out, 1);
        denbad = 0;
        repeat (255) begin
            @(negedge clk);
            if (den_out) denbad++;
        end
        chk("timeout_not_yet", timeout_err, 0);
        @(negedge clk);
        if (den_out) denbad++;
        chk("timeout_set", timeout_err, 1);
        chk("no_den_retrigger", denbad, 0);
        @(negedge clk);
        txn('{4'b0011, 5'h17, 16'h6660, 7'h17, 1'b1, 1, 12'h666});
        chk("timeout_sticky", timeout_err, 1);
        chk("timeout_discard", smp(0), 0);

        // DRDY on the timeout clock wins
        do_reset();
        ch_en = 4'b0011;
        @(negedge clk);
        eoc_in = 1'b1;
        @(negedge clk);
        eoc_in = 1'b0;
        repeat (255) @(negedge clk);
        drdy_in    = 1'b1;
        channel_in = 5'h1e;
        do_in      = 16'hABC0;
        @(negedge clk);
        drdy_in = 1'b0;
        chk("late_drdy_valid", sample_valid, 1);
        chk("late_drdy_sample", smp(0), 12'hABC);
        chk("late_drdy_no_err", timeout_err, 0);
        @(negedge clk);
        chk("late_drdy_no_err2", timeout_err, 0);

        // Disable mid-read
        do_reset();
        ch_en = 4'b1000;
        @(negedge clk);
        txn('{4'b1000, 5'h16, 16'hF000, 7'h16, 1'b1, 3, 12'hF00});
        eoc_in = 1'b1;
        @(negedge clk);
        eoc_in = 1'b0;
        chk("dis_den", den_out, 1);
        ch_en = 4'b0000;
        @(negedge clk);
        chk("dis_sample_clr", smp(3), 0);
        chk("dis_pwm_off", pwm_out[3], 0);
        drdy_in    = 1'b1;
        channel_in = 5'h16;
        do_in      = 16'h7770;
        @(negedge clk);
        drdy_in = 1'b0;
        chk("dis_discard_valid", sample_valid, 0);
        chk("dis_discard_sample", smp(3), 0);
        @(negedge clk);
        chk("idle_daddr", daddr_out, 7'h1e);

        // Reset mid WAIT_DRDY
        do_reset();
        ch_en = 4'b1000;
        @(negedge clk);
        txn('{4'b1000, 5'h16, 16'h5670, 7'h16, 1'b1, 3, 12'h567});
        eoc_in = 1'b1;
        @(negedge clk);
        eoc_in = 1'b0;
        chk("mid_den", den_out, 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_den", den_out, 0);
        chk("mid_rst_daddr", daddr_out, 7'h1e);
        chk("mid_rst_sample_ch", sample_ch, 0);
        chk("mid_rst_samples", sample_out, 0);
        chk("mid_rst_pwm", pwm_out, 0);
        chk("mid_rst_timeout", timeout_err, 0);
        @(negedge clk);
        resetn     = 1'b1;
        drdy_in    = 1'b1;
        channel_in = 5'h16;
        do_in      = 16'h4320;
        @(negedge clk);
        drdy_in = 1'b0;
        chk("post_rst_valid", sample_valid, 0);
        chk("post_rst_sample", smp(3), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
